// File: rtl/tofpet_readout_scheduler.sv
// Round-robin drain of the TofPet event FIFOs into one framed output stream.
// Every grant emits a header word (channel, word count) followed by up to MAX_BURST data words.
module tofpet_readout_scheduler #(
    parameter int NCH       = 6,
    parameter int DW        = 32,
    parameter int UW        = 11,
    parameter int MAX_BURST = 256
) (
    input  logic              CK,
    input  logic              RESETb,
    input  logic              ENABLE,
    input  logic [NCH-1:0]    CH_MASK,
    input  logic [NCH*DW-1:0] FIFO_DATA,
    input  logic [NCH-1:0]    FIFO_EMPTY,
    input  logic [NCH*UW-1:0] FIFO_USED,
    output logic [NCH-1:0]    FIFO_READ,
    output logic [DW-1:0]     OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              OUT_SOP,
    output logic              OUT_EOP,
    output logic              BUSY,
    output logic [31:0]       BURST_CNT
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_BURST);
    localparam logic [3:0]     RR_INIT  = 4'(NCH - 1);
    localparam logic [NCH-1:0] READ_ONE = NCH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_HDR  = 2'd2,
        S_DATA = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      rr_q, rr_d;
    logic [3:0]      g_q, g_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     burst_cnt_q, burst_cnt_d;

    logic [NCH-1:0]  eligible_s;
    logic            grant_found_s;
    logic [3:0]      grant_s;
    logic [UW-1:0]   grant_used_s;
    logic [CW-1:0]   grant_cnt_s;

    assign eligible_s = CH_MASK & ~FIFO_EMPTY;

    // Round-robin search: first eligible channel after the last one served.
    always_comb begin
        grant_found_s = 1'b0;
        grant_s       = 4'd0;
        for (int off = 1; off <= NCH; off++) begin
            if (!grant_found_s && eligible_s[(int'(rr_q) + off) % NCH]) begin
                grant_found_s = 1'b1;
                grant_s       = 4'((int'(rr_q) + off) % NCH);
            end
        end
    end

    // Burst length for the candidate grant; a zero count lagging the empty flag still means one word.
    always_comb begin
        grant_used_s = FIFO_USED[int'(grant_s) * UW +: UW];
        if (32'(grant_used_s) == 32'd0) begin
            grant_cnt_s = CNT_ONE;
        end else if (32'(grant_used_s) > 32'(MAX_BURST)) begin
            grant_cnt_s = CNT_MAX;
        end else begin
            grant_cnt_s = CW'(grant_used_s);
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        g_d         = g_q;
        cnt_d       = cnt_q;
        burst_cnt_d = burst_cnt_q;
        OUT_VALID   = 1'b0;
        OUT_SOP     = 1'b0;
        OUT_EOP     = 1'b0;
        OUT_DATA    = '0;
        FIFO_READ   = '0;
        case (state_q)
            S_IDLE: begin
                if (ENABLE && (|eligible_s)) begin
                    state_d = S_ARB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARB: begin
                if (grant_found_s) begin
                    g_d     = grant_s;
                    rr_d    = grant_s;
                    cnt_d   = grant_cnt_s;
                    state_d = S_HDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                OUT_VALID = 1'b1;
                OUT_SOP   = 1'b1;
                OUT_DATA  = DW'({4'hC, g_q, 8'h00, 16'(cnt_q)});
                if (OUT_READY) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_HDR;
                end
            end
            S_DATA: begin
                OUT_VALID = 1'b1;
                OUT_DATA  = FIFO_DATA[int'(g_q) * DW +: DW];
                OUT_EOP   = (cnt_q == CNT_ONE);
                // No empty check: the burst length never exceeds the occupancy seen at grant time.
                if (OUT_READY) begin
                    FIFO_READ = READ_ONE << g_q;
                    cnt_d     = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        burst_cnt_d = burst_cnt_q + 32'd1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CK) begin
        if (!RESETb) begin
            state_q     <= S_IDLE;
            rr_q        <= RR_INIT;
            g_q         <= 4'd0;
            cnt_q       <= '0;
            burst_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            g_q         <= g_d;
            cnt_q       <= cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign BUSY      = (state_q != S_IDLE);
    assign BURST_CNT = burst_cnt_q;

endmodule

// File: doc/tofpet_readout_scheduler.md
Name: tofpet_readout_scheduler

Overview:
Drains the six TofPet event FIFOs (show-ahead, 32-bit words) into one framed output stream for the Ethernet packet builder. Arbitration is round-robin. Each grant produces a burst of up to MAX_BURST words, preceded by a header word that carries the channel number and the word count. Software controls the block through an enable bit and a channel mask taken from the COMMAND register.

Parameters:
NCH, 6, number of FIFO channels (1..15)
DW, 32, FIFO and output data width
UW, 11, width of each USED_WORDS field
MAX_BURST, 256, maximum data words per grant (1..2047)

Ports:
CK  in  1  100 MHz clock
RESETb  in  1  reset, synchronous, active-low
ENABLE  in  1  scheduler run enable
CH_MASK  in  NCH  per-channel enable, 1 = channel eligible
FIFO_DATA  in  NCH*DW  head word of each FIFO, channel k at [k*DW +: DW]
FIFO_EMPTY  in  NCH  per-channel empty flag
FIFO_USED  in  NCH*UW  per-channel used-word count, channel k at [k*UW +: UW]
FIFO_READ  out  NCH  per-channel pop strobe (show-ahead FIFO)
OUT_DATA  out  DW  output word
OUT_VALID  out  1  OUT_DATA valid
OUT_READY  in  1  downstream accepts the word when OUT_VALID & OUT_READY
OUT_SOP  out  1  high with the header word
OUT_EOP  out  1  high with the last data word of a burst
BUSY  out  1  high in any state other than IDLE
BURST_CNT  out  32  number of completed bursts, wraps at 2^32

Behaviour:
- Reset (RESETb=0 at a CK edge): state IDLE, round-robin pointer rr=NCH-1, FIFO_READ=0, OUT_VALID=0, OUT_SOP=0, OUT_EOP=0, OUT_DATA=0, BUSY=0, BURST_CNT=0. Reset mid-burst aborts the burst immediately. The next non-reset cycle has no FIFO_READ pulse.
- A channel k is eligible when CH_MASK[k]=1 and FIFO_EMPTY[k]=0.
- State IDLE:
  - Go to ARB when ENABLE=1 and at least one channel is eligible; otherwise stay in IDLE.
- State ARB (one cycle):
  - Grant g = first eligible channel searching rr+1, rr+2, ... modulo NCH. Set rr=g.
  - Latch cnt = min(FIFO_USED[g], MAX_BURST). If FIFO_USED[g]=0 (count lags the empty flag), use cnt=1.
  - If no channel is eligible any more, return to IDLE.
- State HDR:
  - OUT_VALID=1, OUT_SOP=1.
  - OUT_DATA = {4'hC, g[3:0], 8'h00, cnt zero-extended to 16 bits}.
  - Hold until OUT_READY=1, then go to DATA.
- State DATA:
  - OUT_DATA = FIFO_DATA[g] (combinational pass-through of the head word). OUT_VALID=1.
  - FIFO_READ[g] = OUT_VALID & OUT_READY. Only one FIFO_READ bit is ever high.
  - Each accepted word decrements cnt. OUT_EOP=1 while cnt=1.
  - On acceptance with cnt=1: BURST_CNT increments and the state goes to IDLE.
  - cnt never exceeds the occupancy, because only the writer side adds words, so the FIFO cannot underflow inside a burst. No empty check is made in DATA.
- OUT_READY low: every output is held stable and FIFO_READ=0 (no data loss, no duplicate words).
- ENABLE or CH_MASK dropping mid-burst: the current burst completes, and the change takes effect at the next ARB/IDLE decision. Bursts are never truncated.
- Minimum per-burst overhead: IDLE→ARB→HDR is 2 cycles from eligibility to header valid. Back-to-back bursts take 1 idle cycle plus 1 ARB cycle between EOP and the next SOP.
- Fairness: after channel g is served, every other eligible channel is served once before g is served again.
- BURST_CNT wraps from 0xFFFFFFFF to 0.
- Registers (reset state, rr, cnt, g, BURST_CNT) update only on the CK rising edge. FIFO_READ and OUT_DATA in DATA are combinational from registered state and the inputs.

Test Plan:
1. Reset, ENABLE=1, CH_MASK=6'h3F, only channel 2 holding 3 words (USED=3) -> header 0xC2000003 with SOP, then the 3 words in order. EOP on the third word, exactly 3 FIFO_READ[2] pulses, BURST_CNT=1, back to IDLE.
2. Channels 0, 3, 5 non-empty with 1 word each, continuous OUT_READY=1 -> grant order 0, 3, 5, then 0 again on refill. SOP-to-SOP spacing is 4 cycles (header, data, IDLE, ARB).
3. Channel 1 USED=600, MAX_BURST=256 -> bursts with counts 256, 256, 88. Each header low field equals its count, and the total number of pops is 600.
4. Random OUT_READY toggling (50%) during a 10-word burst -> OUT_DATA and OUT_VALID stay stable while stalled. FIFO_READ pulses only on accepted words, and all 10 words arrive in order with no duplicates.
5. ENABLE deasserted after the 2nd word of a 5-word burst -> all 5 words are still sent with EOP on the last, then the block stays in IDLE (BUSY=0) while the FIFOs remain non-empty. CH_MASK=0 blocks all grants.
6. RESETb asserted during DATA -> the next cycle has OUT_VALID=0, FIFO_READ=0, BURST_CNT=0. After release, arbitration restarts at channel 0.
